// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor_model front end.
// Optional build macro: SENSOR_NOISE_EN (adds LFSR noise on the low value nibble).
package sensor_pkg;

   localparam int SEQ_W  = 8;
   localparam int VAL_W  = 24;
   localparam int LFSR_W = 16;

   // Seed and tap mask for x^16+x^14+x^13+x^11+1, shifting right.
   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_READY   = 2'd2
   } state_t;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/sensor_lfsr.sv
// 16-bit Fibonacci LFSR used to perturb sample values when SENSOR_NOISE_EN is defined.
module sensor_lfsr
   import sensor_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              step_i,
   output logic [LFSR_W-1:0] state_o
);

   logic [LFSR_W-1:0] state_q;
   logic [LFSR_W-1:0] state_d;

   // Advance once per step; reset and load both reseed.
   always_comb begin
      state_d = state_q;
      if (step_i) state_d = lfsr_next(state_q);
   end

   // Register the LFSR state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst || load_i) state_q <= LFSR_SEED;
      else                state_q <= state_d;
   end

   assign state_o = state_q;

endmodule

// File: rtl/sensor_model.sv
// Behavioural sensor front end: answers sensor_en with a fixed-length conversion
// and presents a ramp sample tagged with a sequence number.
// Optional build macro: SENSOR_NOISE_EN (XOR LFSR[3:0] into the presented value).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for sensor_en
// ST_CONVERT | counting conv_cnt down to zero while sensor_en stays high
// ST_READY   | sensor_ready pulse; sample delivered if sensor_en still high
module sensor_model
   import sensor_pkg::*;
#(
   parameter int CONV_CYCLES = 4,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sensor_en,
   input  logic              sample_restart,
   input  logic [VAL_W-1:0]  cfg_start,
   input  logic [VAL_W-1:0]  cfg_step,
   output logic              sensor_ready,
   output logic [DATA_W-1:0] sensor_out,
   output logic              busy
);

   localparam logic [7:0] CONV_LOAD = 8'(CONV_CYCLES - 1);

   state_t             state_q;
   logic [7:0]         conv_cnt_q;
   logic [SEQ_W-1:0]   seq_q;
   logic [VAL_W-1:0]   acc_q;
   logic               ready_q;
   logic [DATA_W-1:0]  out_q;

   logic               deliver_d;
   logic [VAL_W-1:0]   value_d;

   // A sample is delivered when the controller still requests during READY.
   assign deliver_d = rst && !sample_restart && (state_q == ST_READY) && sensor_en;

`ifdef SENSOR_NOISE_EN
   logic [LFSR_W-1:0] lfsr_state;

   sensor_lfsr u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load_i  (sample_restart),
      .step_i  (deliver_d),
      .state_o (lfsr_state)
   );

   assign value_d = acc_q ^ {20'b0, lfsr_state[3:0]};
`else
   assign value_d = acc_q;
`endif

   // Conversion FSM with registered sample and ready pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         conv_cnt_q <= '0;
         seq_q      <= '0;
         acc_q      <= cfg_start;
         ready_q    <= 1'b0;
         out_q      <= '0;
      end else if (sample_restart) begin
         state_q    <= ST_IDLE;
         conv_cnt_q <= '0;
         seq_q      <= '0;
         acc_q      <= cfg_start;
         ready_q    <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sensor_en) begin
                  state_q    <= ST_CONVERT;
                  conv_cnt_q <= CONV_LOAD;
               end
            end
            ST_CONVERT: begin
               if (!sensor_en) begin
                  state_q <= ST_IDLE;
               end else if (conv_cnt_q == 8'd0) begin
                  state_q <= ST_READY;
                  ready_q <= 1'b1;
                  out_q   <= DATA_W'({seq_q, value_d});
               end else begin
                  conv_cnt_q <= conv_cnt_q - 8'd1;
               end
            end
            ST_READY: begin
               if (sensor_en) begin
                  seq_q      <= seq_q + 8'd1;
                  acc_q      <= acc_q + cfg_step;
                  state_q    <= ST_CONVERT;
                  conv_cnt_q <= CONV_LOAD;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sensor_ready = ready_q;
   assign sensor_out   = out_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sensor_model.sv
// Scoreboard bench for sensor_model (CONV_CYCLES=4).
module tb_sensor_model;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sensor_en = 1'b0;
   logic        sample_restart = 1'b0;
   logic [23:0] cfg_start = 24'h0;
   logic [23:0] cfg_step = 24'h0;
   logic        sensor_ready;
   logic [31:0] sensor_out;
   logic        busy;

   always #5 clk = ~clk;

   sensor_model #(.CONV_CYCLES(4), .DATA_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .sensor_en      (sensor_en),
      .sample_restart (sample_restart),
      .cfg_start      (cfg_start),
      .cfg_step       (cfg_step),
      .sensor_ready   (sensor_ready),
      .sensor_out     (sensor_out),
      .busy           (busy)
   );

   typedef struct {
      logic [31:0] data;
      int          at;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   base;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Presented value after n deliveries since reset/restart.
   function automatic logic [23:0] pv(input logic [23:0] a, input int n);
`ifdef SENSOR_NOISE_EN
      logic [15:0] s;
      s = 16'hACE1;
      repeat (n) s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
      return a ^ {20'b0, s[3:0]};
`else
      return (n < 0) ? 24'h0 : a;
`endif
   endfunction

   task automatic push(input logic [7:0] seq, input logic [23:0] val, input int n, input int at);
      exp_t e;
      e.data = {seq, pv(val, n)};
      e.at   = at;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic restart();
      sample_restart = 1'b1;
      step(1);
      sample_restart = 1'b0;
   endtask

   // Monitor: every ready pulse must match the oldest expectation, at its cycle.
   always @(negedge clk) begin
      if (sensor_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got sensor_out %h expected no pulse (cycle %0d)", sensor_out, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sample_data", sensor_out, e.data);
            chk("sample_cycle", cyc, e.at);
         end
      end
   end

   initial begin
      // Reset state
      cfg_start = 24'h000010;
      cfg_step  = 24'h000002;
      rst = 1'b0;
      step(3);
      chk("rst_ready", {31'b0, sensor_ready}, 32'h0);
      chk("rst_out", sensor_out, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);

      // Continuous ramp: pulses at cycles 5, 10, 15
      rst = 1'b1;
      sensor_en = 1'b1;
      base = cyc;
      push(8'h00, 24'h000010, 0, base + 5);
      push(8'h01, 24'h000012, 1, base + 10);
      push(8'h02, 24'h000014, 2, base + 15);
      step(1);
      chk("busy_convert", {31'b0, busy}, 32'h1);
      step(15);
      sensor_en = 1'b0;
      step(1);
      chk("busy_after_abort", {31'b0, busy}, 32'h0);
      chk("out_holds", sensor_out, {8'h02, pv(24'h000014, 2)});

      // Abort at cycle 3 of a conversion, then re-enable
      cfg_start = 24'h000100;
      cfg_step  = 24'h000005;
      restart();
      sensor_en = 1'b1;
      step(3);
      sensor_en = 1'b0;
      step(1);
      chk("abort_busy", {31'b0, busy}, 32'h0);
      sensor_en = 1'b1;
      base = cyc;
      push(8'h00, 24'h000100, 0, base + 5);
      step(5);
      // sensor_en low during READY: not delivered
      sensor_en = 1'b0;
      step(1);
      chk("undelivered_idle", {31'b0, busy}, 32'h0);
      sensor_en = 1'b1;
      base = cyc;
      push(8'h00, 24'h000100, 0, base + 5);
      step(6);
      sensor_en = 1'b0;
      step(1);
      sensor_en = 1'b1;
      base = cyc;
      push(8'h01, 24'h000105, 1, base + 5);
      step(6);
      sensor_en = 1'b0;
      step(1);

      // 257 samples across the seq and value wrap
      cfg_start = 24'hFFFFF0;
      cfg_step  = 24'h000010;
      restart();
      sensor_en = 1'b1;
      base = cyc;
      for (int i = 0; i < 257; i++)
         push(8'(i), 24'(32'h00FFFFF0 + 32'h10 * i), i, base + 5 * (i + 1));
      step(5 * 257 + 1);
      sensor_en = 1'b0;
      step(1);
      chk("wrap_last_out", sensor_out, {8'h00, pv(24'h000FF0, 256)});
      chk("wrap_busy", {31'b0, busy}, 32'h0);

      // Restart mid-CONVERT after three deliveries
      cfg_start = 24'h000040;
      cfg_step  = 24'h000001;
      restart();
      sensor_en = 1'b1;
      base = cyc;
      push(8'h00, 24'h000040, 0, base + 5);
      push(8'h01, 24'h000041, 1, base + 10);
      push(8'h02, 24'h000042, 2, base + 15);
      step(17);
      restart();
      chk("restart_busy", {31'b0, busy}, 32'h0);
      chk("restart_out_kept", sensor_out, {8'h02, pv(24'h000042, 2)});
      base = cyc;
      push(8'h00, 24'h000040, 0, base + 5);
      step(6);
      sensor_en = 1'b0;
      step(1);

`ifdef SENSOR_NOISE_EN
      cfg_start = 24'h0;
      cfg_step  = 24'h0;
      restart();
      sensor_en = 1'b1;
      push(8'h00, 24'h0, 0, cyc + 5);
      push(8'h01, 24'h0, 1, cyc + 10);
      step(5);
      chk("noise_seed_nibble", sensor_out, 32'h00000001);
      step(5);
      chk("noise_high_bits", {8'h0, sensor_out[23:4], 4'h0}, 32'h0);
      sensor_en = 1'b0;
      step(1);
`endif

      // Reset mid-conversion: no partial sample
      sensor_en = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
      chk("midrst_busy", {31'b0, busy}, 32'h0);
      chk("midrst_out", sensor_out, 32'h0);
      sensor_en = 1'b0;
      rst = 1'b1;
      step(8);

      chk("sb_drained", sb.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
